// File: rtl/vga2_cell_framebuffer.sv
// ============================================================================
// vga2_cell_framebuffer
// ----------------------------------------------------------------------------
// Coarse cell-based frame store that feeds the VGA2 timing interface. Each
// store entry holds a 3-bit {r,g,b} colour for one cell of
// 2^CellShift x 2^CellShift pixels. The store is indexed as
// cell_v*HCells + cell_h.
//
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   fb_addr_h, fb_addr_v    pixel address from the timing interface
//   color_r/g/b             registered colour, one cycle after the address
//   wr_valid/wr_ready       write handshake, one cell per accepted transfer
//   wr_cell_h/wr_cell_v     target cell of a write
//   wr_color                {r,g,b} to store
//   clr_req/clr_color       start a full-store fill with clr_color (IDLE only)
//   busy                    high while the clear engine is running
//
// Optional build macro:
//   VGA2_FB_CLEAR_ON_RESET_EN  when defined, reset starts a black clear so the
//                              store is blanked after every reset.
// ============================================================================
module vga2_cell_framebuffer #(
    parameter int HAddrSize    = 11,
    parameter int VAddrSize    = 11,
    parameter int CellShift    = 3,
    parameter int HCells       = 100,
    parameter int VCells       = 75,
    parameter int CellAddrSize = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [HAddrSize-1:0]    fb_addr_h,
    input  logic [VAddrSize-1:0]    fb_addr_v,
    output logic                    color_r,
    output logic                    color_g,
    output logic                    color_b,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [CellAddrSize-1:0] wr_cell_h,
    input  logic [CellAddrSize-1:0] wr_cell_v,
    input  logic [2:0]              wr_color,
    input  logic                    clr_req,
    input  logic [2:0]              clr_color,
    output logic                    busy
);

    localparam int NumCells  = HCells * VCells;
    localparam int IdxSize   = $clog2(NumCells);
    localparam int HCellSize = HAddrSize - CellShift;
    localparam int VCellSize = VAddrSize - CellShift;
    localparam logic [IdxSize-1:0] LastIdx = IdxSize'(NumCells - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [IdxSize-1:0] clr_ptr_r;
    logic [IdxSize-1:0] clr_ptr_next_s;
    logic [2:0]         clr_color_r;
    logic [2:0]         clr_color_next_s;

    logic [2:0]         mem_r [NumCells];
    logic               mem_we_s;
    logic [IdxSize-1:0] mem_waddr_s;
    logic [2:0]         mem_wdata_s;

    logic [HCellSize-1:0] rd_cell_h_s;
    logic [VCellSize-1:0] rd_cell_v_s;
    logic                 rd_in_range_s;
    logic [IdxSize-1:0]   rd_idx_s;
    logic [2:0]           pix_color_r;

    logic                 wr_in_range_s;
    logic [IdxSize-1:0]   wr_idx_s;

    // The sub-cell pixel bits select nothing; the whole cell shares one colour.
    logic unused_low_bits_s;
    assign unused_low_bits_s = ^{fb_addr_h[CellShift-1:0], fb_addr_v[CellShift-1:0]};

    // Read address decode: cell coordinates, range check and flat index.
    always_comb begin
        rd_cell_h_s   = fb_addr_h[HAddrSize-1:CellShift];
        rd_cell_v_s   = fb_addr_v[VAddrSize-1:CellShift];
        rd_in_range_s = (rd_cell_h_s < HCellSize'(HCells)) &&
                        (rd_cell_v_s < VCellSize'(VCells));
        // Index only formed in range so the array is never addressed past its end.
        if (rd_in_range_s) begin
            rd_idx_s = IdxSize'(rd_cell_v_s) * IdxSize'(HCells) + IdxSize'(rd_cell_h_s);
        end else begin
            rd_idx_s = '0;
        end
    end

    // Write address decode for the client port.
    always_comb begin
        wr_in_range_s = (wr_cell_h < CellAddrSize'(HCells)) &&
                        (wr_cell_v < CellAddrSize'(VCells));
        if (wr_in_range_s) begin
            wr_idx_s = IdxSize'(wr_cell_v) * IdxSize'(HCells) + IdxSize'(wr_cell_h);
        end else begin
            wr_idx_s = '0;
        end
    end

    // Handshake and status outputs; a pending clear request blocks writes.
    always_comb begin
        wr_ready = (state_r == ST_IDLE) && !clr_req;
        busy     = (state_r == ST_CLEAR);
    end

    // Clear FSM next-state logic.
    always_comb begin
        state_next_s     = state_r;
        clr_ptr_next_s   = clr_ptr_r;
        clr_color_next_s = clr_color_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_req) begin
                    state_next_s     = ST_CLEAR;
                    clr_ptr_next_s   = '0;
                    clr_color_next_s = clr_color;
                end else begin
                    state_next_s     = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_ptr_r == LastIdx) begin
                    state_next_s   = ST_IDLE;
                    clr_ptr_next_s = '0;
                end else begin
                    clr_ptr_next_s = clr_ptr_r + IdxSize'(1);
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                clr_ptr_next_s = '0;
            end
        endcase
    end

    // Store write mux: the clear engine owns the port while running.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = 3'b000;
        case (state_r)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_ptr_r;
                mem_wdata_s = clr_color_r;
            end
            ST_IDLE: begin
                // Out-of-range cells complete the handshake but never write.
                if (wr_valid && wr_ready && wr_in_range_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = wr_idx_s;
                    mem_wdata_s = wr_color;
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Clear FSM state, pointer and latched colour registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
`ifdef VGA2_FB_CLEAR_ON_RESET_EN
            state_r     <= ST_CLEAR;
`else
            state_r     <= ST_IDLE;
`endif
            clr_ptr_r   <= '0;
            clr_color_r <= 3'b000;
        end else begin
            state_r     <= state_next_s;
            clr_ptr_r   <= clr_ptr_next_s;
            clr_color_r <= clr_color_next_s;
        end
    end

    // Frame store; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Registered pixel colour; the read samples the pre-write value (read-first).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_color_r <= 3'b000;
        end else if (rd_in_range_s) begin
            pix_color_r <= mem_r[rd_idx_s];
        end else begin
            pix_color_r <= 3'b000;
        end
    end

    assign color_r = pix_color_r[2];
    assign color_g = pix_color_r[1];
    assign color_b = pix_color_r[0];

endmodule
